// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Fetch FSM encoding and pipeline defaults.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } fetch_word_t;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready channel.
// Master is the fetch stage, slave is the memory.
interface imem_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset, then flush, then load, else hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] npc_in,
  output logic [31:0] instr_q,
  output logic [31:0] npc_q,
  output logic        valid_q
);

  logic [31:0] instr_d;
  logic [31:0] npc_d;
  logic        valid_d;

  // Select bubble, new word or current contents.
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      npc_d   = 32'd0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      npc_d   = npc_in;
      valid_d = 1'b1;
    end
  end

  // Register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, hold buffer.
// Drives the IF/ID register through if_id_reg.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  imem_if.master      imem,
  output logic [31:0] instr_IF_ID,
  output logic [31:0] newPC_IF_ID,
  output logic        valid_IF_ID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  fetch_word_t  buf_q, buf_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_nxt;
  logic         reg_load;
  logic         reg_flush;
  fetch_word_t  reg_word;

  assign redirect = jump | pcSrc;
  assign target   = jump ? jumpTarget : branchTarget;
  assign pc_nxt   = pc_plus4(pc_q);

  assign imem.imem_req  = ((state_q == FETCH) ||
                           (state_q == DROP)) && !reset;
  assign imem.imem_addr = pc_q;

  // Next-state, PC and IF/ID control decisions.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    buf_d     = buf_q;
    reg_load  = 1'b0;
    reg_flush = 1'b0;
    reg_word  = '{instr: imem.imem_rdata,
                  npc:   pc_nxt};
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          reg_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = DROP;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_nxt;
          if (hazard) begin
            buf_d   = '{instr: imem.imem_rdata,
                        npc:   pc_nxt};
            state_d = HELD;
          end else begin
            reg_load = 1'b1;
          end
        end else if (!hazard) begin
          reg_flush = 1'b1;
        end
      end
      HELD: begin
        if (redirect) begin
          reg_flush = 1'b1;
          pc_d      = target;
          state_d   = FETCH;
        end else if (!hazard) begin
          reg_load = 1'b1;
          reg_word = buf_q;
          state_d  = FETCH;
        end
      end
      DROP: begin
        reg_flush = 1'b1;
        if (redirect) begin
          pend_d = target;
        end
        if (imem.imem_ready) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // PC, FSM state, hold buffer and pending target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (reg_load),
    .flush   (reg_flush),
    .instr_in(reg_word.instr),
    .npc_in  (reg_word.npc),
    .instr_q (instr_IF_ID),
    .npc_q   (newPC_IF_ID),
    .valid_q (valid_IF_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage.
// Memory returns addr + 0x1000_0000 as the word.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hazard;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] instr_IF_ID;
  logic [31:0] newPC_IF_ID;
  logic        valid_IF_ID;

  imem_if imem ();

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] iw(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign imem.imem_rdata = iw(imem.imem_addr);

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .hazard      (hazard),
    .pcSrc       (pcSrc),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpTarget  (jumpTarget),
    .imem        (imem),
    .instr_IF_ID (instr_IF_ID),
    .newPC_IF_ID (newPC_IF_ID),
    .valid_IF_ID (valid_IF_ID)
  );

  typedef struct {
    logic        hz;
    logic        ps;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [31:0] enpc;
    logic        evalid;
  } vec_t;

  function automatic vec_t mk(
    input logic hz, input logic ps,
    input logic [31:0] bt,
    input logic jp, input logic [31:0] jt,
    input logic rdy, input logic ereq,
    input logic [31:0] eaddr,
    input logic [31:0] einstr,
    input logic [31:0] enpc,
    input logic evalid
  );
    vec_t v;
    v.hz = hz; v.ps = ps; v.bt = bt;
    v.jp = jp; v.jt = jt; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr;
    v.einstr = einstr; v.enpc = enpc;
    v.evalid = evalid;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h want %h",
               idx, nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic rst,
                       input int idx);
    @(negedge clk);
    reset        = rst;
    hazard       = v.hz;
    pcSrc        = v.ps;
    branchTarget = v.bt;
    jump         = v.jp;
    jumpTarget   = v.jt;
    imem.imem_ready = v.rdy;
    #1;
    chk("req", idx, {31'd0, imem.imem_req},
        {31'd0, v.ereq});
    chk("addr", idx, imem.imem_addr, v.eaddr);
    @(posedge clk);
    #1;
    chk("instr", idx, instr_IF_ID, v.einstr);
    chk("newpc", idx, newPC_IF_ID, v.enpc);
    chk("valid", idx, {31'd0, valid_IF_ID},
        {31'd0, v.evalid});
  endtask

  vec_t tbl[23];

  initial begin
    // hz ps bt jp jt rdy | req addr instr npc valid
    tbl[0]  = mk(0,0,0,0,0,1, 1,32'h0,   iw(32'h0),32'h4,1);
    tbl[1]  = mk(0,0,0,0,0,1, 1,32'h4,   iw(32'h4),32'h8,1);
    tbl[2]  = mk(1,0,0,0,0,1, 1,32'h8,   iw(32'h4),32'h8,1);
    tbl[3]  = mk(1,0,0,0,0,1, 0,32'hC,   iw(32'h4),32'h8,1);
    tbl[4]  = mk(1,0,0,0,0,1, 0,32'hC,   iw(32'h4),32'h8,1);
    tbl[5]  = mk(0,0,0,0,0,1, 0,32'hC,   iw(32'h8),32'hC,1);
    tbl[6]  = mk(0,0,0,0,0,1, 1,32'hC,   iw(32'hC),32'h10,1);
    tbl[7]  = mk(0,1,32'h40,0,0,0, 1,32'h10, 0,0,0);
    tbl[8]  = mk(0,0,0,0,0,0, 1,32'h10,  0,0,0);
    tbl[9]  = mk(0,0,0,0,0,1, 1,32'h10,  0,0,0);
    tbl[10] = mk(0,0,0,0,0,1, 1,32'h40,  iw(32'h40),32'h44,1);
    tbl[11] = mk(1,0,0,0,0,1, 1,32'h44,  iw(32'h40),32'h44,1);
    tbl[12] = mk(1,1,32'h40,1,32'h100,1, 0,32'h48, 0,0,0);
    tbl[13] = mk(0,0,0,0,0,1, 1,32'h100, iw(32'h100),32'h104,1);
    tbl[14] = mk(0,1,32'h200,0,0,0, 1,32'h104, 0,0,0);
    tbl[15] = mk(0,0,0,1,32'h300,1, 1,32'h104, 0,0,0);
    tbl[16] = mk(0,0,0,0,0,1, 1,32'h300, iw(32'h300),32'h304,1);
    tbl[17] = mk(0,0,0,0,0,0, 1,32'h304, 0,0,0);
    tbl[18] = mk(0,0,0,0,0,1, 1,32'h304, iw(32'h304),32'h308,1);
    tbl[19] = mk(1,0,0,0,0,0, 1,32'h308, iw(32'h304),32'h308,1);
    tbl[20] = mk(1,0,0,1,32'hFFFF_FFFC,1, 1,32'h308, 0,0,0);
    tbl[21] = mk(0,0,0,0,0,1, 1,32'hFFFF_FFFC,
                 iw(32'hFFFF_FFFC),32'h0,1);
    tbl[22] = mk(0,0,0,0,0,1, 1,32'h0,   iw(32'h0),32'h4,1);

    reset = 1'b1;
    hazard = 1'b0;
    pcSrc = 1'b0;
    branchTarget = '0;
    jump = 1'b0;
    jumpTarget = '0;
    imem.imem_ready = 1'b1;

    apply(mk(0,0,0,0,0,1, 0,32'h0, 0,0,0), 1'b1, 100);
    apply(mk(0,0,0,0,0,1, 0,32'h0, 0,0,0), 1'b1, 101);

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i], 1'b0, i);
    end

    // Reset while waiting in DROP; pending target is dropped.
    apply(mk(0,1,32'h80,0,0,0, 1,32'h4, 0,0,0), 1'b0, 200);
    apply(mk(0,0,0,0,0,0, 1,32'h4, 0,0,0), 1'b0, 201);
    apply(mk(0,0,0,0,0,1, 0,32'h4, 0,0,0), 1'b1, 202);
    apply(mk(0,0,0,0,0,1, 1,32'h0, iw(32'h0),32'h4,1),
          1'b0, 203);
    apply(mk(0,0,0,0,0,1, 1,32'h4, iw(32'h4),32'h8,1),
          1'b0, 204);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, fetches from instruction memory over a req/ready handshake, and drives the IF/ID pipeline register consumed by the decode stage (instr_IF_ID, newPC_IF_ID).
- Honours the hazard unit's stall (hazard) and the branch/jump redirect from downstream.
- Contains a one-entry holding buffer so a fetch that completes during a stall is not lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction written into IF/ID on flush or empty cycle.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hazard  input  1  stall from hazard unit: IF/ID holds, PC does not advance.
- pcSrc  input  1  taken branch; redirect to branchTarget.
- branchTarget  input  32  branch destination.
- jump  input  1  jump; redirect to jumpTarget; has priority over pcSrc.
- jumpTarget  input  32  jump destination.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address (always equals PC).
- imem_ready  input  1  memory completes the request this cycle; imem_rdata is valid.
- imem_rdata  input  32  fetched instruction.
- instr_IF_ID  output  32  IF/ID instruction.
- newPC_IF_ID  output  32  IF/ID PC+4 of that instruction.
- valid_IF_ID  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (synchronous, dominant over all other inputs): PC=RESET_PC; state=FETCH; instr_IF_ID=NOP_INSTR; newPC_IF_ID=0; valid_IF_ID=0; buffer cleared; imem_req=0 during the reset cycle.
- Handshake:
  - imem_req = (state==FETCH or state==DROP) and !reset; imem_addr = PC.
  - Once imem_req is high, PC/addr stays stable until imem_ready is seen.
  - imem_ready is ignored when imem_req=0.
  - Zero-wait memory gives one instruction per cycle.
- Redirect:
  - redirect = jump | pcSrc; target = jump ? jumpTarget : branchTarget.
  - Redirect has priority over hazard.
  - Every redirect flushes IF/ID: NOP_INSTR, valid=0, newPC=0.
- FSM states: FETCH, HELD, DROP.
- FETCH:
  - redirect & imem_ready: fetched word discarded; PC=target; stay FETCH.
  - redirect & !imem_ready: pendTarget=target; go DROP (outstanding request must complete).
  - imem_ready & !hazard: IF/ID={imem_rdata, PC+4, valid=1}; PC=PC+4.
  - imem_ready & hazard: buffer={imem_rdata, PC+4}; PC=PC+4; IF/ID holds; go HELD.
  - !imem_ready & !hazard: IF/ID=bubble (NOP, valid=0).
  - !imem_ready & hazard: IF/ID holds.
- HELD (imem_req=0):
  - redirect: buffer discarded; PC=target; go FETCH.
  - !hazard: IF/ID=buffer with valid=1; go FETCH.
  - hazard: hold everything.
- DROP:
  - imem_ready: data discarded; PC=pendTarget; go FETCH.
  - A new redirect while in DROP overwrites pendTarget (latest wins), including one arriving in the same cycle as imem_ready.
  - IF/ID stays bubble.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Targets are taken unmodified; no alignment checking.
- Latency: instruction appears on IF/ID on the edge after the cycle imem_ready is high.

Decomposition:
- Shared package mips_pkg: NOP_INSTR, RESET_PC default, fetch FSM state enum {FETCH, HELD, DROP}.
- One sub-module, if_id_reg: the IF/ID pipeline register with load/hold/flush controls and synchronous reset.
- PC, holding buffer, pendTarget and FSM stay in if_stage.

Test Plan:
- Reset, then zero-wait memory returning addr-indexed words -> imem_addr 0,4,8; IF/ID newPC 4,8,12, valid=1 each cycle from cycle 2.
- hazard=1 for 3 cycles with imem_ready=1 -> instr at PC 8 buffered; imem_req=0 in HELD; IF/ID unchanged; on hazard drop IF/ID gets that instr, newPC=12, then fetch resumes at 12.
- pcSrc=1, branchTarget=0x40 while memory waits 2 cycles -> DROP; imem_addr stays at old PC until ready; old word never appears; next fetch at 0x40; IF/ID valid=0 meanwhile.
- jump=1 (0x100) and pcSrc=1 (0x40) in the same cycle during HELD -> buffer discarded, next fetch at 0x100.
- reset asserted mid-wait in DROP -> PC=RESET_PC, valid=0, state FETCH next cycle; pendTarget never used.
- PC at 32'hFFFF_FFFC, fetch completes -> newPC_IF_ID=0, next imem_addr=0.
